// File: rtl/step_pulse_generator_if.sv
// Bundles the move command (counts, directions, load strobe) and the driver outputs.
// No logic of its own; latency is whatever the attached generator imposes.
// Loads are accepted only while the generator is idle; busy shows when a load would be dropped.
interface step_pulse_generator_if;
    logic        [8:0]  steps1;
    logic        [8:0]  steps2;
    logic               dir1;
    logic               dir2;
    logic               dataReady;
    logic               step1;
    logic               step2;
    logic               dirOut1;
    logic               dirOut2;
    logic               busy;
    logic               done;
    logic signed [15:0] position1;
    logic signed [15:0] position2;

    // Command source side: issues moves, observes the driver outputs.
    modport master (
        output steps1, steps2, dir1, dir2, dataReady,
        input  step1, step2, dirOut1, dirOut2, busy, done, position1, position2
    );

    // Generator side: consumes moves, produces the driver outputs.
    modport slave (
        input  steps1, steps2, dir1, dir2, dataReady,
        output step1, step2, dirOut1, dirOut2, busy, done, position1, position2
    );
endinterface

// File: rtl/step_pulse_generator.sv
// Two-axis step/direction pulse generator sharing one period timer; tracks signed positions.
// Done asserts on cycle 1 + DIR_SETUP_CYCLES + max(steps1, steps2) * STEP_PERIOD_CYCLES, counting the accepting edge as cycle 1.
// No backpressure: a load is taken only in IDLE; loads arriving while busy are dropped, not queued.
module step_pulse_generator #(
    parameter int DIR_SETUP_CYCLES   = 50,
    parameter int PULSE_HIGH_CYCLES  = 100,
    parameter int STEP_PERIOD_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    step_pulse_generator_if.slave bus
);

    localparam int PULSE_LOW_CYCLES = STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES;
    localparam int TMAX = (DIR_SETUP_CYCLES > STEP_PERIOD_CYCLES) ? DIR_SETUP_CYCLES
                                                                   : STEP_PERIOD_CYCLES;
    // The timer only ever holds a phase length minus one.
    localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP_CYCLES - 1);
    localparam logic [TW-1:0] HIGH_LOAD  = TW'(PULSE_HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD   = TW'(PULSE_LOW_CYCLES - 1);

    // Reject parameter sets that would give zero-length or negative phases.
    if (PULSE_HIGH_CYCLES < 1) begin : g_bad_high
        $error("step_pulse_generator: PULSE_HIGH_CYCLES must be >= 1");
    end
    if (STEP_PERIOD_CYCLES <= PULSE_HIGH_CYCLES) begin : g_bad_period
        $error("step_pulse_generator: STEP_PERIOD_CYCLES must exceed PULSE_HIGH_CYCLES");
    end
    if (DIR_SETUP_CYCLES < 1) begin : g_bad_setup
        $error("step_pulse_generator: DIR_SETUP_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE_HIGH,
        PULSE_LOW,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [8:0]         rem1_q, rem1_d;
    logic [8:0]         rem2_q, rem2_d;
    logic               dir1_q, dir1_d;
    logic               dir2_q, dir2_d;
    logic               step1_q, step1_d;
    logic               step2_q, step2_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [15:0] pos1_q, pos1_d;
    logic signed [15:0] pos2_q, pos2_d;

    logic               any_rem;

    assign any_rem = (rem1_q != 9'd0) || (rem2_q != 9'd0);

    // Next-state, counter, position and output decode; outputs follow the next state so they land in flops.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem1_d  = rem1_q;
        rem2_d  = rem2_q;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;

        case (state_q)
            IDLE: begin
                if (bus.dataReady) begin
                    rem1_d  = bus.steps1;
                    rem2_d  = bus.steps2;
                    dir1_d  = bus.dir1;
                    dir2_d  = bus.dir2;
                    timer_d = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (timer_q == '0) begin
                    if (any_rem) begin
                        timer_d = HIGH_LOAD;
                        state_d = PULSE_HIGH;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            PULSE_HIGH: begin
                if (timer_q == '0) begin
                    // Step is committed only as the high phase completes, so an
                    // interrupted pulse never reaches the position counters.
                    if (rem1_q != 9'd0) begin
                        rem1_d = rem1_q - 9'd1;
                        pos1_d = dir1_q ? pos1_q + 16'sd1 : pos1_q - 16'sd1;
                    end
                    if (rem2_q != 9'd0) begin
                        rem2_d = rem2_q - 9'd1;
                        pos2_d = dir2_q ? pos2_q + 16'sd1 : pos2_q - 16'sd1;
                    end
                    timer_d = LOW_LOAD;
                    state_d = PULSE_LOW;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            PULSE_LOW: begin
                if (timer_q == '0) begin
                    if (any_rem) begin
                        timer_d = HIGH_LOAD;
                        state_d = PULSE_HIGH;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        step1_d = (state_d == PULSE_HIGH) && (rem1_d != 9'd0);
        step2_d = (state_d == PULSE_HIGH) && (rem2_d != 9'd0);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and registered outputs; reset overrides everything at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rem1_q  <= '0;
            rem2_q  <= '0;
            dir1_q  <= 1'b0;
            dir2_q  <= 1'b0;
            step1_q <= 1'b0;
            step2_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pos1_q  <= '0;
            pos2_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem1_q  <= rem1_d;
            rem2_q  <= rem2_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            step1_q <= step1_d;
            step2_q <= step2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
        end
    end

    assign bus.step1     = step1_q;
    assign bus.step2     = step2_q;
    assign bus.dirOut1   = dir1_q;
    assign bus.dirOut2   = dir2_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.position1 = pos1_q;
    assign bus.position2 = pos2_q;

endmodule
